// File: rtl/deposito_pkg.sv
// Shared state encoding, default parameters and stock arithmetic helper for the cork store.
// No logic of its own.
package deposito_pkg;

    localparam int CAPACITY_DEF     = 20;
    localparam int LOW_LEVEL_DEF    = 5;
    localparam int EJECT_CYCLES_DEF = 4;

    localparam logic [1:0] ST_IDLE   = 2'b00;
    localparam logic [1:0] ST_EJECT  = 2'b01;
    localparam logic [1:0] ST_REFILL = 2'b10;

    // Saturating increment: never exceeds cap and never wraps.
    function automatic logic [4:0] sat_inc(input logic [4:0] value, input logic [4:0] cap);
        return (value < cap) ? value + 5'd1 : value;
    endfunction

endpackage

// File: rtl/deposito_rolhas_if.sv
// Dispense/refill requests and stock status between the dispenser FSM and the cork store.
// master drives requests, slave (the store) reports status.
interface deposito_rolhas_if;
    logic       disp;
    logic       add_rolha;
    logic       rolha5;
    logic       eject;
    logic [4:0] stock;
    logic       full;
    logic       low;
    logic       empty;

    modport master (
        output disp, add_rolha,
        input  rolha5, eject, stock, full, low, empty
    );

    modport slave (
        input  disp, add_rolha,
        output rolha5, eject, stock, full, low, empty
    );
endinterface

// File: rtl/detector_borda.sv
// 1-bit rising-edge detector: rise is high while level is 1 and was 0 at the previous clock.
// Output is combinational from level and one register; a held level yields one pulse.
module detector_borda (
    input  logic clk,
    input  logic rst_n,
    input  logic level,
    output logic rise
);
    logic prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) prev <= 1'b0;
        else        prev <= level;
    end

    assign rise = level & ~prev;
endmodule

// File: rtl/deposito_rolhas.sv
// Cork store: counts stock, ejects one cork per dispense edge, accepts refills one per add edge.
// Dispense takes effect one clock after the edge; requests arriving while busy are dropped, not queued.
module deposito_rolhas
    import deposito_pkg::*;
#(
    parameter int CAPACITY     = CAPACITY_DEF,
    parameter int LOW_LEVEL    = LOW_LEVEL_DEF,
    parameter int EJECT_CYCLES = EJECT_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              reset,
    deposito_rolhas_if.slave  bus
);
    localparam logic [4:0] CAP5   = 5'(CAPACITY);
    localparam logic [4:0] LOW5   = 5'(LOW_LEVEL);
    localparam logic [3:0] EJ_TOP = 4'(EJECT_CYCLES - 1);

    // Assertion is immediate; release is held off for two clocks.
    logic [1:0] rst_sync;
    logic       rst_n;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rst_sync <= 2'b00;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end

    assign rst_n = rst_sync[1];

    logic disp_edge;
    logic add_edge;

    detector_borda u_borda_disp (
        .clk   (clk),
        .rst_n (rst_n),
        .level (bus.disp),
        .rise  (disp_edge)
    );

    detector_borda u_borda_add (
        .clk   (clk),
        .rst_n (rst_n),
        .level (bus.add_rolha),
        .rise  (add_edge)
    );

    logic [1:0] state;
    logic [4:0] stock_q;
    logic [3:0] ej_cnt;
    logic       low_seen;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            stock_q  <= 5'd0;
            ej_cnt   <= 4'd0;
            low_seen <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // Dispense wins over a simultaneous add; an empty dispense is ignored.
                    if (disp_edge) begin
                        if (stock_q != 5'd0) begin
                            stock_q <= stock_q - 5'd1;
                            ej_cnt  <= EJ_TOP;
                            state   <= ST_EJECT;
                        end
                    end else if (add_edge) begin
                        stock_q  <= sat_inc(stock_q, CAP5);
                        low_seen <= 1'b0;
                        state    <= ST_REFILL;
                    end
                end
                ST_EJECT: begin
                    if (ej_cnt == 4'd0) state  <= ST_IDLE;
                    else                ej_cnt <= ej_cnt - 4'd1;
                end
                ST_REFILL: begin
                    if (add_edge) stock_q <= sat_inc(stock_q, CAP5);
                    // Leave after add_rolha is sampled low on two consecutive clocks.
                    if (bus.add_rolha)  low_seen <= 1'b0;
                    else if (low_seen)  state    <= ST_IDLE;
                    else                low_seen <= 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.eject  = (state == ST_EJECT);
    assign bus.rolha5 = (state == ST_IDLE) && (stock_q != 5'd0);
    assign bus.stock  = stock_q;
    assign bus.full   = (stock_q == CAP5);
    assign bus.low    = (stock_q < LOW5);
    assign bus.empty  = (stock_q == 5'd0);
endmodule

// File: tb/tb_deposito_rolhas.sv
// Directed bench for the cork store with a scoreboard of expected post-dispense stock values.
module tb_deposito_rolhas;
    localparam int CAP  = 20;
    localparam int LOWL = 5;
    localparam int EJ   = 4;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    deposito_rolhas_if bus ();

    deposito_rolhas #(
        .CAPACITY     (CAP),
        .LOW_LEVEL    (LOWL),
        .EJECT_CYCLES (EJ)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int         checks      = 0;
    int         errors      = 0;
    int         m_stock     = 0;
    int         pulses      = 0;
    int         exp_pulses  = 0;
    int         ej_len      = 0;
    logic       ej_d        = 1'b0;
    logic [4:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Output monitor: every eject rising edge pops one expected stock value.
    always @(negedge clk) begin
        if (bus.eject === 1'b1) begin
            if (!ej_d) begin
                pulses++;
                check("eject_expected", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) check("eject_stock", bus.stock, exp_q.pop_front());
            end
            ej_len++;
            check("rolha5_in_eject", bus.rolha5, 0);
        end else if (ej_d && reset) begin
            check("eject_len", ej_len, EJ);
            ej_len = 0;
        end else begin
            ej_len = 0;
        end
        ej_d = (bus.eject === 1'b1);
    end

    task automatic add_pulse();
        bus.add_rolha = 1'b1;
        if (m_stock < CAP) m_stock++;
        @(negedge clk);
        bus.add_rolha = 1'b0;
        @(negedge clk);
    endtask

    task automatic settle();
        repeat (3) @(negedge clk);
    endtask

    task automatic disp_pulse();
        bus.disp = 1'b1;
        if (m_stock > 0) begin
            m_stock--;
            exp_q.push_back(5'(m_stock));
            exp_pulses++;
        end
        @(negedge clk);
        bus.disp = 1'b0;
        repeat (EJ + 2) @(negedge clk);
    endtask

    initial begin
        bus.disp      = 1'b0;
        bus.add_rolha = 1'b0;
        reset         = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_rolha5", bus.rolha5, 0);
        check("rst_eject",  bus.eject,  0);
        check("rst_stock",  bus.stock,  0);
        check("rst_full",   bus.full,   0);
        check("rst_low",    bus.low,    1);
        check("rst_empty",  bus.empty,  1);
        reset = 1'b1;
        repeat (4) @(negedge clk);

        // Three refill pulses, then REFILL exit two low cycles after the last one.
        add_pulse();
        check("refill_rolha5", bus.rolha5, 0);
        add_pulse();
        add_pulse();
        check("refill_hold", bus.rolha5, 0);
        @(negedge clk);
        check("refill_exit_rolha5", bus.rolha5, 1);
        check("refill_stock", bus.stock, m_stock);
        check("refill_low",   bus.low,   1);
        check("refill_empty", bus.empty, 0);

        // Held dispense level yields exactly one pulse.
        bus.disp = 1'b1;
        m_stock--;
        exp_q.push_back(5'(m_stock));
        exp_pulses++;
        repeat (10) @(negedge clk);
        bus.disp = 1'b0;
        repeat (2) @(negedge clk);
        check("held_pulses", pulses, exp_pulses);
        check("held_stock",  bus.stock, m_stock);
        check("held_rolha5", bus.rolha5, 1);

        // Dispense at empty is ignored.
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        m_stock = 0;
        repeat (4) @(negedge clk);
        disp_pulse();
        check("empty_stock",  bus.stock,  0);
        check("empty_eject",  bus.eject,  0);
        check("empty_pulses", pulses, exp_pulses);
        add_pulse();
        settle();
        check("empty_then_add_stock",  bus.stock,  1);
        check("empty_then_add_rolha5", bus.rolha5, 1);

        // Fill to CAPACITY-1, then three more edges saturate.
        while (m_stock < CAP - 1) add_pulse();
        settle();
        check("stock19",      bus.stock, 19);
        check("stock19_full", bus.full,  0);
        repeat (3) add_pulse();
        settle();
        check("sat_stock", bus.stock, CAP);
        check("sat_full",  bus.full,  1);
        check("sat_low",   bus.low,   0);

        // Drain to 5, then simultaneous dispense and add.
        while (m_stock > 5) disp_pulse();
        check("stock5",     bus.stock, 5);
        check("stock5_low", bus.low,   0);
        bus.disp      = 1'b1;
        bus.add_rolha = 1'b1;
        m_stock--;
        exp_q.push_back(5'(m_stock));
        exp_pulses++;
        repeat (EJ + 3) @(negedge clk);
        bus.disp      = 1'b0;
        bus.add_rolha = 1'b0;
        settle();
        check("simul_stock", bus.stock, 4);
        check("simul_low",   bus.low,   1);
        check("simul_full",  bus.full,  0);

        // Reset in the second eject cycle.
        bus.disp = 1'b1;
        m_stock--;
        exp_q.push_back(5'(m_stock));
        exp_pulses++;
        @(negedge clk);
        bus.disp = 1'b0;
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("abort_eject",  bus.eject,  0);
        check("abort_stock",  bus.stock,  0);
        check("abort_rolha5", bus.rolha5, 0);
        m_stock = 0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        check("post_abort_eject", bus.eject, 0);
        check("post_abort_empty", bus.empty, 1);
        add_pulse();
        settle();
        check("post_abort_stock",  bus.stock,  1);
        check("post_abort_rolha5", bus.rolha5, 1);

        check("scoreboard_drained", exp_q.size(), 0);
        check("total_pulses", pulses, exp_pulses);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/deposito_rolhas.md
DEPOSITO_ROLHAS -- requirements
Module: deposito_rolhas

Interface
REQ-001 Parameter CAPACITY, default 20, SHALL set the maximum cork stock (1..31).
REQ-002 Parameter LOW_LEVEL, default 5, SHALL set the low-stock warning threshold (stock < LOW_LEVEL).
REQ-003 Parameter EJECT_CYCLES, default 4, SHALL set the eject actuator pulse length in clocks (1..15).
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 reset  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 disp  input  1  SHALL be the dispense request from the dispenser FSM; level, one request per rising edge.
REQ-007 add_rolha  input  1  SHALL be the refill request; one cork added per rising edge.
REQ-008 rolha5  output  1  SHALL indicate that a cork is available and the block accepts a dispense.
REQ-009 eject  output  1  SHALL drive the cork ejector actuator.
REQ-010 stock  output  5  SHALL report the current cork count, unsigned.
REQ-011 full, low, empty  output  1 each  SHALL flag stock==CAPACITY, stock<LOW_LEVEL, and stock==0.

Function
REQ-012 Rising edges of disp and add_rolha SHALL be detected from registered previous values; a level held high counts once.
REQ-013 FSM states SHALL be IDLE, EJECT, and REFILL.
REQ-014 rolha5 SHALL equal (state==IDLE) AND (stock!=0), registered-state derived, no combinational path from inputs.
REQ-015 IDLE + disp edge + stock!=0 SHALL decrement stock by 1 and enter EJECT on the next clock.
REQ-016 IDLE + disp edge + stock==0 SHALL be ignored: stay in IDLE, stock unchanged, eject low.
REQ-017 eject SHALL be high for exactly EJECT_CYCLES clocks, starting the first cycle in EJECT, then return to IDLE.
REQ-018 disp and add_rolha edges during EJECT SHALL be ignored (not queued).
REQ-019 IDLE + add_rolha edge (no disp edge) SHALL enter REFILL and increment stock if stock<CAPACITY.
REQ-020 In REFILL, each add_rolha edge SHALL increment stock, saturating at CAPACITY; edges at full are dropped without wrap.
REQ-021 REFILL SHALL return to IDLE after add_rolha has been low for 2 consecutive cycles; disp edges in REFILL are ignored.
REQ-022 Simultaneous disp and add_rolha edges in IDLE SHALL be resolved in favour of dispense; add is dropped.
REQ-023 full/low/empty SHALL be combinational decodes of the stock register, valid in every state.
REQ-024 The stock arithmetic SHALL be 5-bit unsigned with no underflow below 0 or overflow above CAPACITY.

Reset
REQ-025 reset low SHALL immediately force state=IDLE, stock=0, eject=0, the eject counter=0, and the edge registers=0.
REQ-026 After reset, outputs SHALL be rolha5=0, eject=0, stock=0, full=0, low=1, empty=1.
REQ-027 Reset asserted mid-EJECT SHALL abort the pulse at once; the already-decremented cork is not restored.
REQ-028 Reset deassertion SHALL be synchronised to clk internally (two-flop release) before the FSM leaves reset.

Structure
REQ-029 A shared package deposito_pkg SHALL hold the state encoding (IDLE=2'b00, EJECT=2'b01, REFILL=2'b10) and the default parameter constants.
REQ-030 One sub-module, detector_borda (1-bit rising-edge detector with async active-low reset), SHALL be instantiated twice.
REQ-031 The eject counter SHALL be a 4-bit down-counter local to deposito_rolhas.

Verification
REQ-032 Reset, then 3 add_rolha pulses (1-cycle high, 1-cycle low) -> stock=3, REFILL exits 2 cycles after the last low, then rolha5=1, low=1, empty=0.
REQ-033 stock=3, disp held high 10 cycles -> exactly one eject pulse of 4 cycles, stock=2, and rolha5 low during EJECT.
REQ-034 stock=0, disp edge -> no eject, stock=0, state stays IDLE.
REQ-035 stock=19, 3 add_rolha edges -> stock=20, full=1, and no wrap.
REQ-036 stock=5, disp and add_rolha rising in the same cycle -> eject issued, stock=4, low=1, and add dropped.
REQ-037 reset pulled low in the 2nd eject cycle -> eject=0 asynchronously and stock=0; after release the FSM is in IDLE.
